rv32e_lsu: RTL

RV32E_LSU -- requirements
Module: rv32e_lsu

---
 rtl/rv32e_lsu.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32e_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : rv32e_lsu
//  Purpose  : RV32E load/store unit. Accepts one CPU load/store request at a
//             time and validates funct3 and alignment. It performs a single
//             word-addressed memory access with byte-lane enables, and returns
//             a sign/zero-extended load result or an error. A cycle counter
//             aborts accesses that do not receive mem_ack in time.
//  Ports    : clk, reset (async, active-low)
//             req_*   : CPU request handshake (req_valid/req_ready)
//             resp_*  : one-cycle response pulse with rdata / error
//             mem_*   : data memory request, byte lanes, read data and ack
//  Revision : 1.0  initial release
// ============================================================================
module rv32e_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr_bus,
    output logic [31:0] mem_write_data_bus,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_read_data_bus,
    input  logic        mem_ack
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    // The counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int               c_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               w_req_legal;
    logic               w_req_misal;
    logic               w_req_err;
    logic               w_timeout;
    logic [31:0]        w_lane;
    logic [31:0]        w_load_data;

    // Request decode, evaluated on the raw inputs at the handshake.
    always_comb begin
        w_req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_req_legal = 1'b1;
            3'b100, 3'b101:         w_req_legal = !req_we;   // LBU/LHU have no store form
            default:                w_req_legal = 1'b0;
        endcase
        w_req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    assign w_req_err = !w_req_legal || w_req_misal;

    // Ack in the final counted cycle wins over the timeout.
    assign w_timeout = (cnt_q == c_CNT_LAST) && !mem_ack;

    // Move the addressed byte/halfword down to bit 0, then extend.
    assign w_lane = mem_read_data_bus >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_data = {24'd0, w_lane[7:0]};
            3'b101:  w_load_data = {16'd0, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (req_valid) begin
                    state_d = w_req_err ? c_ST_RESP : c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    state_d = c_ST_RESP;
                end
            end
            c_ST_RESP: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // Request capture, wait counter and response data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= '0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= '0;
                        rdata_q  <= 32'd0;
                        err_q    <= w_req_err;
                    end
                end
                c_ST_ACCESS: begin
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'd0 : w_load_data;
                        err_q   <= 1'b0;
                    end else if (w_timeout) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                default: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from the current state only.
    always_comb begin
        req_ready          = 1'b0;
        resp_valid         = 1'b0;
        resp_rdata         = 32'd0;
        resp_error         = 1'b0;
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        mem_addr_bus       = 32'd0;
        mem_write_data_bus = 32'd0;
        mem_byte_en        = 4'd0;
        case (state_q)
            c_ST_IDLE: req_ready = 1'b1;
            c_ST_ACCESS: begin
                mem_req      = 1'b1;
                mem_we       = we_q;
                mem_addr_bus = {addr_q[31:2], 2'b00};
                case (funct3_q[1:0])
                    2'b00: begin
                        mem_byte_en        = 4'b0001 << addr_q[1:0];
                        mem_write_data_bus = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_byte_en        = 4'b0011 << addr_q[1:0];
                        mem_write_data_bus = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_byte_en        = 4'b1111;
                        mem_write_data_bus = wdata_q;
                    end
                endcase
            end
            c_ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_error = err_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
